// File: rtl/flags_register_unit.sv
// rtl/flags_register_unit.sv - architected NZCV flags register with one-entry exception shadow
module flags_register_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic [1:0] FlagWriteE,
  input  logic       CondExE,
  input  logic [3:0] ALUFlagsE,
  input  logic       SaveFlags,
  input  logic       RestoreFlags,
  output logic [3:0] FlagsE,
  output logic       FlagsUpdated,
  output logic       ShadowValid,
  output logic       FlagErr
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} shadowState_t;

  shadowState_t shadowState, shadowStateNext;
  logic [3:0]   flags, flagsNext;
  logic [3:0]   shadow, shadowNext;
  logic         flagErrNext;
  logic         upd, legalSave, legalRestore;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadowState  <= EMPTY;
      flags        <= RESET_FLAGS;
      shadow       <= 4'b0000;
      FlagsUpdated <= 1'b0;
      FlagErr      <= 1'b0;
    end else begin
      shadowState  <= shadowStateNext;
      flags        <= flagsNext;
      shadow       <= shadowNext;
      FlagsUpdated <= (flagsNext != flags);
      FlagErr      <= flagErrNext;
    end
  end

  always_comb begin
    shadowStateNext = shadowState;
    flagsNext       = flags;
    shadowNext      = shadow;
    flagErrNext     = 1'b0;
    upd             = 1'b0;
    legalSave       = 1'b0;
    legalRestore    = 1'b0;
    if (!StallE) begin
      upd          = ~FlushE & CondExE;
      legalSave    = SaveFlags & ~RestoreFlags & (shadowState == EMPTY);
      legalRestore = RestoreFlags & ~SaveFlags & (shadowState == FULL);
      flagErrNext  = (SaveFlags | RestoreFlags) & ~legalSave & ~legalRestore;
      if (upd && FlagWriteE[1]) flagsNext[3:2] = ALUFlagsE[3:2];
      if (upd && FlagWriteE[0]) flagsNext[1:0] = ALUFlagsE[1:0];
      // Shadow captures the pre-update flags, so a save alongside an ALU write keeps the old value.
      if (legalSave) begin
        shadowNext      = flags;
        shadowStateNext = FULL;
      end
      if (legalRestore) begin
        flagsNext       = shadow;
        shadowStateNext = EMPTY;
      end
    end
  end

  assign FlagsE      = flags;
  assign ShadowValid = (shadowState == FULL);

endmodule

// File: tb/tb_flags_register_unit.sv
// tb/tb_flags_register_unit.sv - directed-vector bench for flags_register_unit
module tb_flags_register_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       StallE, FlushE, CondExE, SaveFlags, RestoreFlags;
  logic [1:0] FlagWriteE;
  logic [3:0] ALUFlagsE;
  logic [3:0] FlagsE;
  logic       FlagsUpdated, ShadowValid, FlagErr;

  int vectorCount = 0;
  int missCount   = 0;

  flags_register_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .FlagWriteE(FlagWriteE), .CondExE(CondExE), .ALUFlagsE(ALUFlagsE),
    .SaveFlags(SaveFlags), .RestoreFlags(RestoreFlags),
    .FlagsE(FlagsE), .FlagsUpdated(FlagsUpdated), .ShadowValid(ShadowValid),
    .FlagErr(FlagErr)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [3:0] f, input logic fu, input logic sv, input logic er);
    checkVal({tag, ".FlagsE"}, FlagsE, f);
    checkVal({tag, ".FlagsUpdated"}, {3'b0, FlagsUpdated}, {3'b0, fu});
    checkVal({tag, ".ShadowValid"}, {3'b0, ShadowValid}, {3'b0, sv});
    checkVal({tag, ".FlagErr"}, {3'b0, FlagErr}, {3'b0, er});
  endtask

  task automatic drive(input logic st, input logic fl, input logic [1:0] fw, input logic ce,
                       input logic [3:0] alu, input logic sv, input logic rs);
    StallE = st; FlushE = fl; FlagWriteE = fw; CondExE = ce;
    ALUFlagsE = alu; SaveFlags = sv; RestoreFlags = rs;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 2'b00, 0, 4'b0000, 0, 0);
    #12;
    checkAll("reset", 4'b0000, 0, 0, 0);
    reset = 1'b0;

    // ALU write and pulse
    drive(0, 0, 2'b11, 1, 4'b1010, 0, 0); step();
    checkAll("wr1010", 4'b1010, 1, 0, 0);
    drive(0, 0, 2'b00, 1, 4'b1010, 0, 0); step();
    checkAll("pulseDrop", 4'b1010, 0, 0, 0);

    // independent halves
    drive(0, 0, 2'b10, 1, 4'b0101, 0, 0); step();
    checkAll("nzOnly", 4'b0110, 1, 0, 0);
    drive(0, 0, 2'b01, 1, 4'b0001, 0, 0); step();
    checkAll("cvOnly", 4'b0101, 1, 0, 0);
    drive(0, 0, 2'b11, 1, 4'b0101, 0, 0); step();
    checkAll("sameValue", 4'b0101, 0, 0, 0);

    // gating
    drive(0, 0, 2'b11, 0, 4'b1111, 0, 0); step();
    checkAll("condFail", 4'b0101, 0, 0, 0);
    drive(0, 1, 2'b11, 1, 4'b1111, 0, 0); step();
    checkAll("flush", 4'b0101, 0, 0, 0);
    drive(1, 0, 2'b11, 1, 4'b1111, 1, 0); step();
    checkAll("stall1", 4'b0101, 0, 0, 0);
    step();
    checkAll("stall2", 4'b0101, 0, 0, 0);

    // save with ALU write, restore overriding ALU write
    drive(0, 0, 2'b11, 1, 4'b1000, 1, 0); step();
    checkAll("saveAlu", 4'b1000, 1, 1, 0);
    drive(0, 0, 2'b11, 1, 4'b0011, 0, 1); step();
    checkAll("restoreAlu", 4'b0101, 1, 0, 0);

    // errors
    drive(0, 0, 2'b00, 0, 4'b0000, 0, 1); step();
    checkAll("restoreEmpty", 4'b0101, 0, 0, 1);
    drive(0, 0, 2'b00, 0, 4'b0000, 0, 0); step();
    checkAll("errDrop", 4'b0101, 0, 0, 0);
    drive(0, 1, 2'b11, 1, 4'b1111, 1, 0); step();
    checkAll("saveFlushed", 4'b0101, 0, 1, 0);
    drive(0, 0, 2'b11, 1, 4'b1100, 0, 0); step();
    checkAll("wr1100", 4'b1100, 1, 1, 0);
    drive(0, 0, 2'b00, 0, 4'b0000, 1, 0); step();
    checkAll("saveFull", 4'b1100, 0, 1, 1);
    drive(0, 0, 2'b00, 0, 4'b0000, 1, 1); step();
    checkAll("saveRestoreBoth", 4'b1100, 0, 1, 1);
    drive(0, 0, 2'b00, 0, 4'b0000, 0, 0); step();
    checkAll("errIdle", 4'b1100, 0, 1, 0);
    drive(0, 0, 2'b00, 0, 4'b0000, 0, 1); step();
    checkAll("restoreFirst", 4'b0101, 1, 0, 0);

    // back to FULL with flags 1100, then async reset
    drive(0, 0, 2'b11, 1, 4'b1100, 1, 0); step();
    checkAll("refill", 4'b1100, 1, 1, 0);
    drive(0, 0, 2'b00, 0, 4'b0000, 1, 0); step();
    checkAll("preReset", 4'b1100, 0, 1, 1);
    #2;
    reset = 1'b1;
    #1;
    checkAll("asyncReset", 4'b0000, 0, 0, 0);
    step();
    reset = 1'b0;
    drive(0, 0, 2'b00, 0, 4'b0000, 0, 0); step();
    checkAll("postReset", 4'b0000, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
